// File: rtl/butterfly_twiddle_pipe_if.sv
// Handshake and data bundle for one twiddle butterfly stage.
// master = upstream/downstream environment, slave = the butterfly itself.
interface butterfly_twiddle_pipe_if #(
  parameter int WORD_SZ = 16
);
  logic               i_valid;
  logic               o_ready;
  logic [WORD_SZ-1:0] in1;
  logic [WORD_SZ-1:0] in2;
  logic [WORD_SZ-1:0] i_twiddle;
  logic               i_inverse;
  logic               i_scale;
  logic               o_valid;
  logic               i_ready;
  logic [WORD_SZ-1:0] out1;
  logic [WORD_SZ-1:0] out2;
  logic               o_ovf;
  logic               i_ovf_clr;

  modport master (
    output i_valid, in1, in2, i_twiddle, i_inverse, i_scale, i_ready, i_ovf_clr,
    input  o_ready, o_valid, out1, out2, o_ovf
  );

  modport slave (
    input  i_valid, in1, in2, i_twiddle, i_inverse, i_scale, i_ready, i_ovf_clr,
    output o_ready, o_valid, out1, out2, o_ovf
  );
endinterface

// File: rtl/butterfly_twiddle_pipe.sv
// Radix-2 DIT butterfly with complex twiddle multiply, 3-stage pipeline.
// out1 = A + B*W, out2 = A - B*W (W conjugated in inverse mode).
// Stage 1 registers operands, stage 2 registers the scaled products,
// stage 3 is the saturated output register. All stages stall together.
module butterfly_twiddle_pipe #(
  parameter int WORD_SZ = 16,
  parameter int TW_FRAC = WORD_SZ/2 - 2
) (
  input logic i_CLK,
  input logic i_RESET,
  butterfly_twiddle_pipe_if.slave bus
);
  localparam int HALF = WORD_SZ/2;
  // Products are HALF x (HALF+1) bits; the sum of two needs one more bit.
  localparam int PW   = 2*HALF + 2;
  localparam int SW   = PW + 1;
  localparam int MAXV = 2**(HALF-1) - 1;
  localparam int MINV = -(2**(HALF-1));

  logic adv;

  logic                   s1_valid, s1_scale;
  logic signed [HALF-1:0] s1_ar, s1_ai, s1_br, s1_bi, s1_wr;
  logic signed [HALF:0]   s1_wi;

  logic                   s2_valid, s2_scale;
  logic signed [HALF-1:0] s2_ar, s2_ai;
  logic signed [PW-1:0]   s2_pr, s2_pi;

  logic signed [HALF:0]   wi_in;
  logic signed [PW-1:0]   pr_full, pi_full;
  logic signed [SW-1:0]   sum1_r, sum1_i, sum2_r, sum2_i;
  logic [HALF-1:0]        q1r, q1i, q2r, q2i;
  logic [3:0]             sat_hit;

  // Returns {saturated, clipped value}.
  function automatic logic [HALF:0] sat(input logic signed [SW-1:0] v);
    if (v > SW'(MAXV))
      return {1'b1, HALF'(MAXV)};
    else if (v < SW'(MINV))
      return {1'b1, HALF'(MINV)};
    else
      return {1'b0, v[HALF-1:0]};
  endfunction

  assign adv         = bus.i_ready | ~bus.o_valid;
  assign bus.o_ready = adv;

  // Conjugate the twiddle on entry; one extra bit keeps -(-2^(HALF-1)) exact.
  always_comb begin
    wi_in = (HALF+1)'($signed(bus.i_twiddle[HALF-1:0]));
    if (bus.i_inverse)
      wi_in = -wi_in;
  end

  // Full-width complex product B*W, then drop the twiddle fraction bits.
  always_comb begin
    pr_full = PW'(s1_br) * PW'(s1_wr) - PW'(s1_bi) * PW'(s1_wi);
    pi_full = PW'(s1_br) * PW'(s1_wi) + PW'(s1_bi) * PW'(s1_wr);
  end

  // Butterfly sums, optional halving, saturation back to HALF bits.
  always_comb begin
    sum1_r = SW'(s2_ar) + SW'(s2_pr);
    sum1_i = SW'(s2_ai) + SW'(s2_pi);
    sum2_r = SW'(s2_ar) - SW'(s2_pr);
    sum2_i = SW'(s2_ai) - SW'(s2_pi);
    if (s2_scale) begin
      sum1_r = sum1_r >>> 1;
      sum1_i = sum1_i >>> 1;
      sum2_r = sum2_r >>> 1;
      sum2_i = sum2_i >>> 1;
    end
    {sat_hit[0], q1r} = sat(sum1_r);
    {sat_hit[1], q1i} = sat(sum1_i);
    {sat_hit[2], q2r} = sat(sum2_r);
    {sat_hit[3], q2i} = sat(sum2_i);
  end

  // Pipeline registers; the whole pipe moves only when the output can advance.
  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      s1_valid    <= 1'b0;
      s2_valid    <= 1'b0;
      bus.o_valid <= 1'b0;
      bus.out1    <= '0;
      bus.out2    <= '0;
    end else if (adv) begin
      s1_valid    <= bus.i_valid;
      s1_scale    <= bus.i_scale;
      s1_ar       <= bus.in1[WORD_SZ-1:HALF];
      s1_ai       <= bus.in1[HALF-1:0];
      s1_br       <= bus.in2[WORD_SZ-1:HALF];
      s1_bi       <= bus.in2[HALF-1:0];
      s1_wr       <= bus.i_twiddle[WORD_SZ-1:HALF];
      s1_wi       <= wi_in;

      s2_valid    <= s1_valid;
      s2_scale    <= s1_scale;
      s2_ar       <= s1_ar;
      s2_ai       <= s1_ai;
      s2_pr       <= pr_full >>> TW_FRAC;
      s2_pi       <= pi_full >>> TW_FRAC;

      bus.o_valid <= s2_valid;
      bus.out1    <= {q1r, q1i};
      bus.out2    <= {q2r, q2i};
    end
  end

  // Sticky overflow; a new saturation beats a simultaneous clear.
  always_ff @(posedge i_CLK) begin
    if (i_RESET)
      bus.o_ovf <= 1'b0;
    else if (adv && s2_valid && (|sat_hit))
      bus.o_ovf <= 1'b1;
    else if (bus.i_ovf_clr)
      bus.o_ovf <= 1'b0;
  end
endmodule
